pc_fetch_sequencer: RTL and testbench

- Owns the architectural PC and sequences instruction fetch.
- Issues one request at a time to instruction memory over a req/ack handshake and presents each fetched word to decode over a valid/ready handshake.
- Advances the PC by 4 after each fetch, or loads a redirect target when a branch or jump resolves.
- Sits between the PC+4 adder path, instruction memory and the decode stage; it replaces the free-running PC register.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/pc_fetch_sequencer_if.sv | 32 +++
 rtl/pc_fetch_sequencer_add4.sv | 14 +
 rtl/pc_fetch_sequencer.sv | 124 ++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg: shared fetch-sequencer state encoding and PC constants       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package cpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'h0000_0003;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr & WORD_ALIGN_MASK) == 32'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_fetch_sequencer_if: imem, decode and redirect signals of fetch     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface pc_fetch_sequencer_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        misalign_err;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err,
        input  imem_ack, imem_rdata, instr_ready, stall, redirect_valid, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err,
        output imem_ack, imem_rdata, instr_ready, stall, redirect_valid, redirect_target
    );

endinterface
`default_nettype wire

// File: rtl/pc_fetch_sequencer_add4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_fetch_sequencer_add4: PC+4 adder, wraps modulo 2^32               |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module pc_fetch_sequencer_add4 (
    input  logic [31:0] a_i,
    output logic [31:0] sum_o
);

    assign sum_o = a_i + 32'd4;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_fetch_sequencer: owns the PC, one imem fetch at a time to decode  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module pc_fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_fetch_sequencer_if.master bus
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] sq_addr_q, sq_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        squash_q, squash_d;
    logic [31:0] pc_inc;
    logic        tgt_ok;

    generate
        if (PC_STEP == 32'd4) begin : g_add4
            pc_fetch_sequencer_add4 u_add4 (
                .a_i   (pc_q),
                .sum_o (pc_inc)
            );
        end else begin : g_add_step
            assign pc_inc = pc_q + PC_STEP;
        end
    endgenerate

    assign tgt_ok = is_word_aligned(bus.redirect_target);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            sq_addr_q <= '0;
            instr_q   <= '0;
            ipc_q     <= '0;
            squash_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            sq_addr_q <= sq_addr_d;
            instr_q   <= instr_d;
            ipc_q     <= ipc_d;
            squash_q  <= squash_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sq_addr_d = sq_addr_q;
        instr_d   = instr_q;
        ipc_d     = ipc_q;
        squash_d  = squash_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                if (bus.redirect_valid) begin
                    if (tgt_ok) pc_d = bus.redirect_target;
                    else        state_d = S_ERR;
                end
            end
            S_FETCH: begin
                if (bus.redirect_valid) begin
                    if (!tgt_ok) begin
                        state_d  = S_ERR;
                        squash_d = 1'b0;
                    end else begin
                        pc_d = bus.redirect_target;
                        if (bus.imem_ack) begin
                            squash_d = 1'b0;
                        end else if (!squash_q) begin
                            // In-flight request keeps its address until the ack retires it
                            squash_d  = 1'b1;
                            sq_addr_d = pc_q;
                        end
                    end
                end else if (bus.imem_ack) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                    end else begin
                        instr_d = bus.imem_rdata;
                        ipc_d   = pc_q;
                        pc_d    = pc_inc;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.redirect_valid) begin
                    if (tgt_ok) begin
                        pc_d    = bus.redirect_target;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (bus.instr_ready && !bus.stall) begin
                    state_d = S_FETCH;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
        endcase
    end

    assign bus.imem_req     = (state_q == S_FETCH);
    assign bus.imem_addr    = squash_q ? sq_addr_q : pc_q;
    assign bus.instr_valid  = (state_q == S_HOLD);
    assign bus.instr        = instr_q;
    assign bus.instr_pc     = ipc_q;
    assign bus.misalign_err = (state_q == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pc_fetch_sequencer: vector table, random vs model, PC wrap check   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RST_PC  = 32'h0000_3000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;

    pc_fetch_sequencer_if bus ();
    pc_fetch_sequencer_if bus2 ();

    pc_fetch_sequencer #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    pc_fetch_sequencer #(.RESET_PC(WRAP_PC), .PC_STEP(32'd4)) u_dut_wrap (
        .clk   (clk),
        .reset (rst2_n),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        r;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        stall;
        logic        rv;
        logic [31:0] rt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_err;
    } vec_t;

    localparam int NVEC = 24;
    vec_t tbl [NVEC];

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] m_pc, m_old, m_instr, m_ipc;
    bit          m_busy, m_have, m_dead, m_drop;

    function automatic vec_t mk(input logic r, a, input logic [31:0] d,
                                input logic rd, st, rv, input logic [31:0] t,
                                input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ei, ep,
                                input logic ee);
        return '{r, a, d, rd, st, rv, t, er, ea, ev, ei, ep, ee};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, ack, input logic [31:0] rdata,
                         input logic ready, stall, rv, input logic [31:0] rt);
        rst_n               = r;
        bus.imem_ack        = ack;
        bus.imem_rdata      = rdata;
        bus.instr_ready     = ready;
        bus.stall           = stall;
        bus.redirect_valid  = rv;
        bus.redirect_target = rt;
    endtask

    task automatic model_step(input bit r, ack, input logic [31:0] rdata,
                              input bit ready, stall, rv, input logic [31:0] rt);
        if (!r) begin
            m_pc = RST_PC; m_old = 0; m_instr = 0; m_ipc = 0;
            m_busy = 0; m_have = 0; m_dead = 0; m_drop = 0;
        end else if (m_dead) begin
            m_dead = 1;
        end else if (rv) begin
            if (rt % 4 != 0) begin
                m_dead = 1; m_busy = 0; m_have = 0; m_drop = 0;
            end else if (m_busy && !ack) begin
                if (!m_drop) begin m_drop = 1; m_old = m_pc; end
                m_pc = rt;
            end else begin
                m_drop = 0; m_have = 0; m_busy = 1; m_pc = rt;
            end
        end else if (m_busy) begin
            if (ack) begin
                if (m_drop) m_drop = 0;
                else begin
                    m_instr = rdata; m_ipc = m_pc; m_have = 1; m_busy = 0;
                    m_pc = m_pc + 32'd4;
                end
            end
        end else if (m_have) begin
            if (ready && !stall) begin m_have = 0; m_busy = 1; end
        end else begin
            m_busy = 1;
        end
    endtask

    initial begin
        rst2_n = 1'b0;
        bus2.imem_ack = 0; bus2.imem_rdata = 0; bus2.instr_ready = 0;
        bus2.stall = 0; bus2.redirect_valid = 0; bus2.redirect_target = 0;

        tbl[0]  = mk(0,0,0,0,0,0,0,                 0,32'h3000,0,0,0,0);
        tbl[1]  = mk(1,0,0,1,0,0,0,                 1,32'h3000,0,0,0,0);
        tbl[2]  = mk(1,0,0,1,0,0,0,                 1,32'h3000,0,0,0,0);
        tbl[3]  = mk(1,1,32'hAAAA0001,1,0,0,0,      0,32'h3004,1,32'hAAAA0001,32'h3000,0);
        tbl[4]  = mk(1,0,0,1,0,0,0,                 1,32'h3004,0,32'hAAAA0001,32'h3000,0);
        tbl[5]  = mk(1,1,32'hBBBB0002,0,0,0,0,      0,32'h3008,1,32'hBBBB0002,32'h3004,0);
        tbl[6]  = mk(1,0,0,1,1,0,0,                 0,32'h3008,1,32'hBBBB0002,32'h3004,0);
        tbl[7]  = mk(1,0,0,1,1,0,0,                 0,32'h3008,1,32'hBBBB0002,32'h3004,0);
        tbl[8]  = mk(1,0,0,1,1,0,0,                 0,32'h3008,1,32'hBBBB0002,32'h3004,0);
        tbl[9]  = mk(1,0,0,1,0,0,0,                 1,32'h3008,0,32'hBBBB0002,32'h3004,0);
        tbl[10] = mk(1,0,0,0,0,1,32'h4000,          1,32'h3008,0,32'hBBBB0002,32'h3004,0);
        tbl[11] = mk(1,0,0,0,0,0,0,                 1,32'h3008,0,32'hBBBB0002,32'h3004,0);
        tbl[12] = mk(1,1,32'hDEAD3008,0,0,0,0,      1,32'h4000,0,32'hBBBB0002,32'h3004,0);
        tbl[13] = mk(1,1,32'hCCCC4000,0,0,0,0,      0,32'h4004,1,32'hCCCC4000,32'h4000,0);
        tbl[14] = mk(1,0,0,1,0,1,32'h5000,          1,32'h5000,0,32'hCCCC4000,32'h4000,0);
        tbl[15] = mk(1,0,0,0,0,1,32'h4002,          0,32'h5000,0,32'hCCCC4000,32'h4000,1);
        tbl[16] = mk(1,1,32'h9,1,0,1,32'h6000,      0,32'h5000,0,32'hCCCC4000,32'h4000,1);
        tbl[17] = mk(0,0,0,0,0,0,0,                 0,32'h3000,0,0,0,0);
        tbl[18] = mk(1,0,0,0,0,0,0,                 1,32'h3000,0,0,0,0);
        tbl[19] = mk(1,1,32'hDEAD0000,1,0,1,32'h7000, 1,32'h7000,0,0,0,0);
        tbl[20] = mk(1,1,32'h77770000,0,0,0,0,      0,32'h7004,1,32'h77770000,32'h7000,0);
        tbl[21] = mk(0,0,0,0,0,0,0,                 0,32'h3000,0,0,0,0);
        tbl[22] = mk(1,0,0,0,0,1,32'h8000,          1,32'h8000,0,0,0,0);
        tbl[23] = mk(1,1,32'h88880000,0,0,0,0,      0,32'h8004,1,32'h88880000,32'h8000,0);

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].r, tbl[i].ack, tbl[i].rdata, tbl[i].ready,
                  tbl[i].stall, tbl[i].rv, tbl[i].rt);
            @(posedge clk); #1;
            chk($sformatf("row%0d req", i),   {31'd0, bus.imem_req},     {31'd0, tbl[i].e_req});
            chk($sformatf("row%0d addr", i),  bus.imem_addr,             tbl[i].e_addr);
            chk($sformatf("row%0d valid", i), {31'd0, bus.instr_valid},  {31'd0, tbl[i].e_valid});
            chk($sformatf("row%0d instr", i), bus.instr,                 tbl[i].e_instr);
            chk($sformatf("row%0d ipc", i),   bus.instr_pc,              tbl[i].e_ipc);
            chk($sformatf("row%0d err", i),   {31'd0, bus.misalign_err}, {31'd0, tbl[i].e_err});
        end

        // randomized run against the reference model
        m_dead = 0;
        for (int i = 0; i < 3000; i++) begin
            logic        r, a, rd, st, rv;
            logic [31:0] d, t;
            logic [98:0] act, exp;
            r  = !(i == 0 || $urandom_range(0, 149) == 0 ||
                   (m_dead && $urandom_range(0, 7) == 0));
            a  = ($urandom_range(0, 2) == 0);
            d  = $urandom;
            rd = $urandom_range(0, 1) == 1;
            st = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 11) == 0);
            t  = $urandom;
            t[1:0] = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            drive(r, a, d, rd, st, rv, t);
            @(posedge clk);
            model_step(r, a, d, rd, st, rv, t);
            #1;
            act = {bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr,
                   bus.instr_pc, bus.misalign_err};
            exp = {m_busy, (m_drop ? m_old : m_pc), m_have, m_instr, m_ipc, m_dead};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL rnd cycle %0d actual=%h expected=%h", i, act, exp);
            end
        end

        // PC wrap and mid-fetch reset on the second instance
        drive(1, 0, 0, 0, 0, 0, 0);
        rst2_n = 0;
        @(posedge clk); #1;
        chk("wrap reset req",  {31'd0, bus2.imem_req}, 32'd0);
        chk("wrap reset addr", bus2.imem_addr, WRAP_PC);
        rst2_n = 1;
        @(posedge clk); #1;
        chk("wrap first req",  {31'd0, bus2.imem_req}, 32'd1);
        chk("wrap first addr", bus2.imem_addr, WRAP_PC);
        bus2.imem_ack = 1; bus2.imem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        chk("wrap held ipc",   bus2.instr_pc, WRAP_PC);
        chk("wrap held instr", bus2.instr, 32'h1234_5678);
        bus2.imem_ack = 0; bus2.instr_ready = 1;
        @(posedge clk); #1;
        chk("wrap next req",   {31'd0, bus2.imem_req}, 32'd1);
        chk("wrap next addr",  bus2.imem_addr, 32'h0000_0000);
        rst2_n = 0; bus2.instr_ready = 0;
        @(posedge clk); #1;
        chk("midfetch reset req",   {31'd0, bus2.imem_req}, 32'd0);
        chk("midfetch reset valid", {31'd0, bus2.instr_valid}, 32'd0);
        chk("midfetch reset addr",  bus2.imem_addr, WRAP_PC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
